fifo_256: RTL and testbench

FIFO_256 -- requirements
Module: fifo_256

---
 rtl/fifo_256.sv | 90 +++++++++
 tb/tb_fifo_256.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_256.sv
// fifo_256: synchronous single-clock FIFO, DEPTH = 2**ADDR_WIDTH words.
// Data_out is registered and loads on an accepted read with one cycle of latency.
// Full and empty flags are decoded from the registered occupancy count.
`timescale 1ns/1ps

module fifo_256 #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  In_Busy,
    output logic                  Out_Busy,
    output logic [ADDR_WIDTH:0]   Count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic rd_accept;
    logic wr_accept;
    logic full;
    logic empty;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Accept decisions and next-state for pointers, occupancy and read data.
    // A write into a full FIFO is still taken when a read frees a slot on the same edge;
    // a read on an empty FIFO never falls through to the incoming write data.
    always_comb begin
        rd_accept  = rd_en && !empty;
        wr_accept  = wr_en && (!full || rd_accept);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state and read data register; reset discards all stored entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= Data_in;
        end
    end

    assign Data_out = data_out_q;
    assign Count    = count_q;
    assign In_Busy  = full;
    assign Out_Busy = empty;

endmodule

// File: tb/tb_fifo_256.sv
// tb_fifo_256: randomized and directed stimulus against a queue-based FIFO model,
// with a scoreboard monitor that checks each read result one edge after the read.
`timescale 1ns/1ps

module tb_fifo_256;

    localparam int DW    = 256;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] dout;
    logic          in_busy;
    logic          out_busy;
    logic [AW:0]   count;

    fifo_256 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .Data_in  (data_in),
        .Data_out (dout),
        .In_Busy  (in_busy),
        .Out_Busy (out_busy),
        .Count    (count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check_state();
        int sz;
        sz = model_q.size();
        check_val("count", DW'(count), DW'(sz));
        check_val("in_busy", DW'(in_busy), DW'(sz == DEPTH));
        check_val("out_busy", DW'(out_busy), DW'(sz == 0));
    endtask

    // One clock of stimulus: check the previous edge's result, drive, update the model.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        logic rd_acc, wr_acc;
        @(negedge clk);
        check_state();
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        rd_acc = r && (model_q.size() > 0);
        wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
        if (rd_acc) exp_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(d);
    endtask

    // Reset pulse placed between clock edges; outputs must clear with no edge.
    task automatic async_reset();
        @(negedge clk);
        check_state();
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        exp_q.delete();
        check_val("rst_count", DW'(count), '0);
        check_val("rst_out_busy", DW'(out_busy), DW'(1));
        check_val("rst_in_busy", DW'(in_busy), '0);
        check_val("rst_data_out", dout, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: on every edge with a read presented to a non-empty FIFO, compare against
    // the scoreboard; otherwise Data_out must hold its last value.
    logic [DW-1:0] prev_dout = '0;
    logic [DW-1:0] exp_word;
    logic          fire;
    always @(posedge clk) begin
        fire = rst_n && rd_en && !out_busy;
        #1;
        if (!rst_n) begin
            prev_dout = '0;
        end else if (fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read actual=%0h required=no_read at %0t", dout, $time);
            end else begin
                exp_word = exp_q.pop_front();
                check_val("data_out", dout, exp_word);
                prev_dout = exp_word;
            end
        end else begin
            check_val("data_out_hold", dout, prev_dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wb, rb;
        repeat (2) @(negedge clk);
        check_val("init_data_out", dout, '0);
        check_state();
        rst_n = 1'b1;

        // Reads on an empty FIFO are ignored.
        repeat (3) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Fill to full, one ignored write, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, DW'(9));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Pointer wrap-around.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd_word());
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(8'hA0 + i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rnd_word());
        step(1'b1, 1'b1, DW'(8'hEE));
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Simultaneous read and write while empty: no fall-through.
        step(1'b1, 1'b1, DW'(8'h55));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Reset mid-operation, then traffic honored right after release.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rnd_word());
        async_reset();
        step(1'b1, 1'b0, DW'(8'h77));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Random traffic with drifting write/read bias and occasional resets.
        wb = 60;
        rb = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                wb = $urandom_range(90, 20);
                rb = $urandom_range(90, 20);
            end
            if ($urandom_range(99) == 0) async_reset();
            else step($urandom_range(99) < wb, $urandom_range(99) < rb, rnd_word());
        end

        for (int i = 0; i <= DEPTH && model_q.size() > 0; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check_val("scoreboard_drained", DW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
